div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Sequential signed 32-bit integer divider for the processor's multicycle execute path. It sits beside the single-cycle ALU, which covers add, sub, and, or and the shifts. The processor presents operands with a one-cycle start strobe; the unit iterates one quotient bit per clock and returns quotient, remainder and an exception flag with a one-cycle ready pulse. The pipeline stalls on busy.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
data_operandA  input  DATA_WIDTH  dividend, two's complement
data_operandB  input  DATA_WIDTH  divisor, two's complement
ctrl_DIV  input  1  start strobe; sampled only in IDLE
data_result  output  DATA_WIDTH  quotient, registered
data_remainder  output  DATA_WIDTH  remainder, registered
data_exception  output  1  divide-by-zero or overflow for the current result
data_resultRDY  output  1  one-cycle pulse: outputs valid
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (edge with reset=1): state IDLE, counter 0. data_result, data_remainder, data_exception, data_resultRDY and busy all 0. Reset overrides everything, including mid-CALC; the partial result is discarded.
- States: IDLE, CALC, DONE.
- IDLE, ctrl_DIV=1 at edge N: latch operands.
  - B==0: data_exception<=1, quotient 0, remainder 0; go to DONE.
  - A==0x80000000 and B==0xFFFFFFFF: data_exception<=1, quotient 0x80000000, remainder 0; go to DONE.
  - Otherwise: latch |A| and |B|, sign_q=A[31]^B[31], sign_r=A[31]; clear the partial remainder; counter<=0; go to CALC.
- CALC: one restoring step per edge.
  - Shift {rem,quo} left 1.
  - Trial-subtract |B| from rem using a DATA_WIDTH+1-bit subtractor.
  - If non-negative, keep the difference and set quo[0]=1.
  - counter++. After DATA_WIDTH steps (edge N+32), go to DONE.
- DONE, entered from CALC:
  - At the entry edge, register the sign-corrected results: quotient negated if sign_q, remainder negated if sign_r.
  - Quotient truncates toward zero; the remainder's sign follows the dividend.
  - data_resultRDY=1 for exactly the cycle in DONE.
  - Next edge: go to IDLE, data_resultRDY<=0.
- Latency:
  - Normal: RDY high in the cycle following edge N+33.
  - Exception: RDY high in the cycle following edge N+1.
- data_result, data_remainder and data_exception hold their values until the next accepted start. A new accept clears data_exception unless the new operation also excepts.
- ctrl_DIV while busy=1 (CALC or DONE) is ignored. No queueing; operands are not re-sampled.
- Operand changes after edge N have no effect.
- Special cases:
  - |A|<|B|: quotient 0, remainder = A.
  - A=0: quotient 0, remainder 0, no exception.
  - B=1: quotient = A.
  - B=-1 with A != 0x80000000: quotient = -A.

Test Plan:
1. A=100, B=7, ctrl_DIV pulse at edge N -> busy 1 from N; RDY only in the cycle after N+33; result=14, remainder=2, exception 0.
2. A=-100, B=7, then A=100, B=-7 -> results -14 / rem -2, then -14 / rem 2. A=-100, B=-7 -> 14 / rem -2.
3. A=7, B=0 -> RDY after edge N+1, exception 1, result 0, rem 0. A following normal op 9/3 -> 3 / rem 0, exception 0.
4. A=0x80000000, B=-1 -> RDY after N+1, exception 1, result 0x80000000. A=0x80000000, B=1 -> 0x80000000 after full latency, exception 0.
5. Start 50/5. Pulse ctrl_DIV with 9/3 at cycle N+10 and during the DONE cycle -> single RDY, result 10, rem 0; no second RDY.
6. Start 1000/3, assert reset at cycle N+10 -> next cycle all outputs 0, busy 0; no RDY. A fresh 1000/3 -> 333 / rem 1 at full latency.

Source files
------------

// File: rtl/div_unit.sv
// Sequential signed restoring divider, one quotient bit per clock.
// Returns quotient, remainder and an exception flag with a ready pulse.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_DIV,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic [DATA_WIDTH-1:0] data_remainder,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic                  busy
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST    = CW'(W);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic          sgnq_q, sgnq_d;
    logic          sgnr_q, sgnr_d;
    logic          exc_q, exc_d;
    logic [W-1:0]  res_q, res_d;
    logic [W-1:0]  remo_q, remo_d;

    logic          a_neg;
    logic          b_neg;
    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic          div_zero;
    logic          ovf;
    logic [W-1:0]  rem_sh;
    logic [W:0]    diff;

    assign a_neg    = data_operandA[W-1];
    assign b_neg    = data_operandB[W-1];
    assign abs_a    = a_neg ? -data_operandA : data_operandA;
    assign abs_b    = b_neg ? -data_operandB : data_operandB;
    assign div_zero = (data_operandB == '0);
    assign ovf      = (data_operandA == MIN_NEG) && (data_operandB == '1);

    // rem < |B| <= 2^(W-1), so the shifted remainder always fits in W bits
    assign rem_sh = {rem_q[W-2:0], quo_q[W-1]};
    assign diff   = {1'b0, rem_sh} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        exc_d   = exc_q;
        res_d   = res_q;
        remo_d  = remo_q;
        unique case (state_q)
            IDLE: begin
                if (ctrl_DIV) begin
                    rem_d   = '0;
                    exc_d   = div_zero | ovf;
                    state_d = CALC;
                    if (div_zero || ovf) begin
                        // Skip the iterations; the fix-up edge publishes these
                        quo_d  = ovf ? MIN_NEG : '0;
                        sgnq_d = 1'b0;
                        sgnr_d = 1'b0;
                        cnt_d  = LAST;
                    end else begin
                        quo_d  = abs_a;
                        dvs_d  = abs_b;
                        sgnq_d = a_neg ^ b_neg;
                        sgnr_d = a_neg;
                        cnt_d  = '0;
                    end
                end
            end
            CALC: begin
                if (cnt_q == LAST) begin
                    res_d   = sgnq_q ? -quo_q : quo_q;
                    remo_d  = sgnr_q ? -rem_q : rem_q;
                    state_d = DONE;
                end else begin
                    quo_d = {quo_q[W-2:0], ~diff[W]};
                    rem_d = diff[W] ? rem_sh : diff[W-1:0];
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            exc_q   <= 1'b0;
            res_q   <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            exc_q   <= exc_d;
            res_q   <= res_d;
            remo_q  <= remo_d;
        end
    end

    assign data_result    = res_q;
    assign data_remainder = remo_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized operations.
module tb_div_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } res_t;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ctrl;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    logic         rdy;
    logic         busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (A),
        .data_operandB  (B),
        .ctrl_DIV       (ctrl),
        .data_result    (res),
        .data_remainder (rem),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t o;
        int   sa;
        int   sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            o = '{q: '0, r: '0, e: 1'b1};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            o = '{q: 32'h8000_0000, r: '0, e: 1'b1};
        end else begin
            o.q = sa / sb;
            o.r = sa % sb;
            o.e = 1'b0;
        end
        return o;
    endfunction

    // Reference model: what the unit must be doing after each edge
    res_t        nxt;
    res_t        m_res = '0;
    bit          m_busy = 1'b0;
    bit          m_exc = 1'b0;
    bit          m_rst = 1'b0;
    int unsigned cyc = 0;
    int unsigned m_rdy_e = 0;

    assign nxt = ref_div(A, B);

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        m_rst <= reset;
        if (reset) begin
            m_busy <= 1'b0;
            m_exc  <= 1'b0;
        end else if (m_busy) begin
            if (cyc == m_rdy_e + 1) m_busy <= 1'b0;
        end else if (ctrl) begin
            m_busy  <= 1'b1;
            m_res   <= nxt;
            m_exc   <= nxt.e;
            m_rdy_e <= cyc + (nxt.e ? 1 : 33);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (cyc > 0) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("rdy", 32'(rdy), 32'(m_busy && (cyc - 1 == m_rdy_e)));
            check("exception", 32'(exc), 32'(m_exc));
            if (m_busy && (cyc - 1 == m_rdy_e)) begin
                check("quotient", res, m_res.q);
                check("remainder", rem, m_res.r);
            end
            if (m_rst) begin
                check("reset quotient", res, '0);
                check("reset remainder", rem, '0);
            end
        end
    end

    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clock);
        #1;
        A    = a;
        B    = b;
        ctrl = 1'b1;
        @(posedge clock);
        #1;
        ctrl = 1'b0;
        A    = $urandom;
        B    = $urandom;
    endtask

    // Returns the number of negedges until rdy, or 0 on timeout
    task automatic wait_rdy(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (rdy) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            vectors++;
            errors++;
            $display("FAIL rdy timeout at cycle %0d: got none, expected pulse", cyc);
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] lq, input logic [W-1:0] lr,
                          input logic le, input int lat);
        int n;
        do_start(a, b);
        wait_rdy(n);
        if (n != 0) begin
            check("lit latency", n, lat);
            check("lit quotient", res, lq);
            check("lit remainder", rem, lr);
            check("lit exception", 32'(exc), 32'(le));
        end
    endtask

    task automatic count_rdy(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (rdy) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        reset = 1'b1;
        ctrl  = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        run_op(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 34);
        run_op(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 34);
        run_op(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 34);
        run_op(32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 2);
        run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 2);
        run_op(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 34);
        run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34);
        run_op(32'd0, -32'sd5, 32'd0, 32'd0, 1'b0, 34);

        // Starts while busy, including in the DONE cycle, are ignored
        do_start(32'd50, 32'd5);
        repeat (9) @(posedge clock);
        #1;
        A    = 32'd9;
        B    = 32'd3;
        ctrl = 1'b1;
        @(posedge clock);
        #1;
        ctrl = 1'b0;
        wait_rdy(n);
        check("busy-start quotient", res, 32'd10);
        check("busy-start remainder", rem, 32'd0);
        A    = 32'd9;
        B    = 32'd3;
        ctrl = 1'b1;
        @(posedge clock);
        #1;
        ctrl = 1'b0;
        count_rdy(40, cnt);
        check("no second rdy", cnt, 0);

        // Reset mid-calculation discards the operation
        do_start(32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rdy", 32'(rdy), 32'd0);
        check("reset result", res, 32'd0);
        check("reset exc", 32'(exc), 32'd0);
        count_rdy(40, cnt);
        check("rdy after reset", cnt, 0);
        run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 34);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = '1; end
                2: rb = 32'd1;
                3: rb = '1;
                4: ra = '0;
                5: begin ra = $urandom_range(0, 200) - 100; rb = $urandom_range(1, 20); end
                6: rb = $urandom_range(0, 15) - 8;
                default: ;
            endcase
            do_start(ra, rb);
            wait_rdy(n);
            repeat ($urandom_range(0, 3)) @(posedge clock);
        end

        repeat (3) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
